// File: rtl/risc_fetch_unit_if.sv
// Bus bundle for the fetch unit: instruction-memory request/response,
// redirect input and the prefetch-queue head presented to the decoder.
interface risc_fetch_unit_if #(
    parameter int PC_W = 5,
    parameter int IR_W = 13
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [IR_W-1:0] imem_rdata;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [IR_W-1:0] ir;
    logic [PC_W-1:0] ir_pc;
    logic            ir_valid;
    logic            ir_ready;
    logic [PC_W-1:0] pc;

    modport master (
        output imem_req, imem_addr, ir, ir_pc, ir_valid, pc,
        input  imem_valid, imem_rdata, redirect, redirect_pc, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir, ir_pc, ir_valid, pc,
        output imem_valid, imem_rdata, redirect, redirect_pc, ir_ready
    );
endinterface

// File: rtl/risc_fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM feeding a small
// prefetch FIFO, with redirect flush and stale-response dropping.
//
//   state  | meaning
//   S_REQ  | may issue a fetch when the queue has room for its response
//   S_WAIT | one request outstanding, response will be queued
//   S_DROP | one request outstanding, response will be discarded
module risc_fetch_unit #(
    parameter int          PC_W     = 5,
    parameter int          IR_W     = 13,
    parameter int          DEPTH    = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    risc_fetch_unit_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = PC_W + IR_W;
    localparam logic [PC_W-1:0] RESET_ADDR = PC_W'(RESET_PC);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  req_pc_q, req_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];

    logic issue;
    logic push;
    logic pop;
    logic not_empty;

    assign not_empty = (count_q != '0);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        issue    = 1'b0;
        push     = 1'b0;
        pop      = not_empty && bus.ir_ready && !bus.redirect;

        case (state_q)
            S_REQ: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                end else if (count_q < CNT_W'(DEPTH)) begin
                    issue    = 1'b1;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_W'(1);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect) begin
                    pc_d    = bus.redirect_pc;
                    state_d = bus.imem_valid ? S_REQ : S_DROP;
                end else if (bus.imem_valid) begin
                    push    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                end
                if (bus.imem_valid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // A redirect empties the queue outright; push/pop are already masked.
        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {req_pc_q, bus.imem_rdata};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_ADDR;
            req_pc_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries counted by count_q are ever shown.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.imem_req  = issue && !rst;
    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.ir_valid  = not_empty;
    assign bus.ir        = not_empty ? mem_q[rd_ptr_q][IR_W-1:0] : '0;
    assign bus.ir_pc     = not_empty ? mem_q[rd_ptr_q][ENT_W-1:IR_W] : '0;

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Self-checking bench for risc_fetch_unit: behavioural instruction memory,
// expected-fetch scoreboard checked on every consumer pop.
module tb_risc_fetch_unit;
    localparam int PC_W = 5;
    localparam int IR_W = 13;

    logic clk;
    logic rst;

    risc_fetch_unit_if #(.PC_W(PC_W), .IR_W(IR_W)) bus ();

    risc_fetch_unit #(.PC_W(PC_W), .IR_W(IR_W), .DEPTH(2), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int mem_lat = 1;
    bit mem_en  = 1'b0;
    logic [PC_W+IR_W-1:0] exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [IR_W-1:0] instr_of(input logic [PC_W-1:0] a);
        logic [IR_W-1:0] v;
        v = {8'd0, a};
        return 13'h0208 + v * 13'h0111;
    endfunction

    // Memory model: a request seen high mid-cycle is accepted at the next
    // edge; data returns mem_lat cycles after acceptance for one cycle.
    initial begin
        logic [PC_W-1:0] a;
        forever begin
            @(negedge clk);
            if (mem_en && !rst && bus.imem_req) begin
                a = bus.imem_addr;
                repeat (mem_lat) @(posedge clk);
                #1;
                bus.imem_valid = 1'b1;
                bus.imem_rdata = instr_of(a);
                @(posedge clk);
                #1;
                bus.imem_valid = 1'b0;
            end
        end
    end

    // Scoreboard: every accepted pop must match the oldest expected fetch.
    initial begin
        logic [PC_W+IR_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.ir_valid && bus.ir_ready && !bus.redirect) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_extra: got pc=%h ir=%h, expected no instruction", bus.ir_pc, bus.ir);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.ir_pc, bus.ir} !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard_pop: got pc=%h ir=%h, expected pc=%h ir=%h",
                                 bus.ir_pc, bus.ir, e[PC_W+IR_W-1:IR_W], e[IR_W-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic [PC_W-1:0] a);
        exp_q.push_back({a, instr_of(a)});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        mem_en          = 1'b0;
        bus.redirect    = 1'b0;
        bus.ir_ready    = 1'b0;
        bus.imem_valid  = 1'b0;
        repeat (6) @(posedge clk);
        exp_q.delete();
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(output bit timed_out);
        int g = 0;
        while (exp_q.size() != 0 && g < 60) begin
            next_cycle();
            g++;
        end
        bus.ir_ready = 1'b0;
        timed_out = (exp_q.size() != 0);
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.imem_valid  = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.ir_ready    = 1'b0;
        #2;
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req: got %b expected 0", bus.imem_req); end
        n_tests++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %b expected 0", bus.ir_valid); end
        n_tests++; if (bus.ir !== '0) begin n_fail++; $display("FAIL reset_ir: got %h expected 0", bus.ir); end
        n_tests++; if (bus.ir_pc !== '0) begin n_fail++; $display("FAIL reset_ir_pc: got %h expected 0", bus.ir_pc); end
        n_tests++; if (bus.pc !== 5'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", bus.pc); end
    endtask

    task automatic test_stream();
        bit to;
        do_reset();
        mem_en = 1'b1; mem_lat = 1; bus.ir_ready = 1'b1;
        for (int a = 0; a < 6; a++) push_exp(5'(a));
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'd0) begin n_fail++; $display("FAIL stream_first_req: got req=%b addr=%h expected req=1 addr=00", bus.imem_req, bus.imem_addr); end
        n_tests++; if (bus.pc !== 5'd0) begin n_fail++; $display("FAIL stream_pc0: got %h expected 00", bus.pc); end
        @(negedge clk);
        n_tests++; if (bus.ir_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stream_wait: got ir_valid=%b req=%b expected 0 0", bus.ir_valid, bus.imem_req); end
        n_tests++; if (bus.pc !== 5'd1) begin n_fail++; $display("FAIL stream_pc1: got %h expected 01", bus.pc); end
        @(negedge clk);
        n_tests++; if (bus.ir_valid !== 1'b1 || bus.ir !== 13'h0208 || bus.ir_pc !== 5'd0) begin n_fail++; $display("FAIL stream_first_ir: got v=%b ir=%h pc=%h expected 1 0208 00", bus.ir_valid, bus.ir, bus.ir_pc); end
        repeat (9) @(posedge clk);
        #1;
        n_tests++; if (exp_q.size() != 1) begin n_fail++; $display("FAIL stream_rate: got %0d pending expected 1", exp_q.size()); end
        n_tests++; if (bus.pc !== 5'd6) begin n_fail++; $display("FAIL stream_pc_rate: got %h expected 06", bus.pc); end
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL stream_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit to;
        int reqs = 0;
        do_reset();
        mem_en = 1'b1; mem_lat = 1;
        for (int a = 0; a < 4; a++) push_exp(5'(a));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imem_req) reqs++;
        end
        n_tests++; if (reqs != 2) begin n_fail++; $display("FAIL bp_req_count: got %0d expected 2", reqs); end
        n_tests++; if (bus.ir_valid !== 1'b1 || bus.ir !== instr_of(5'd0) || bus.ir_pc !== 5'd0) begin n_fail++; $display("FAIL bp_head: got v=%b ir=%h pc=%h expected 1 %h 00", bus.ir_valid, bus.ir, bus.ir_pc, instr_of(5'd0)); end
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_stall_req: got %b expected 0", bus.imem_req); end
        next_cycle();
        bus.ir_ready = 1'b1;
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_drop();
        bit to;
        bit found = 1'b0;
        int cyc = 0;
        logic [PC_W-1:0] first_addr = '0;
        do_reset();
        mem_en = 1'b1; mem_lat = 3; bus.ir_ready = 1'b1;
        for (int a = 0; a < 3; a++) push_exp(5'(a));
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == 5'd3) found = 1'b1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rd_find_req3: got none expected request to 03"); end
        next_cycle();
        bus.redirect = 1'b1; bus.redirect_pc = 5'h10;
        exp_q.delete();
        push_exp(5'h10); push_exp(5'h11);
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rd_req_in_wait: got %b expected 0", bus.imem_req); end
        next_cycle();
        bus.redirect = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rd_flushed: got %b expected 0", bus.ir_valid); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.imem_req) begin found = 1'b1; first_addr = bus.imem_addr; end
        end
        n_tests++; if (!found || first_addr !== 5'h10) begin n_fail++; $display("FAIL rd_next_addr: got found=%b addr=%h expected 1 10", found, first_addr); end
        n_tests++; if (cyc != 2) begin n_fail++; $display("FAIL rd_drop_delay: got %0d cycles expected 2", cyc); end
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL rd_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_redirect_coincident();
        bit to;
        do_reset();
        mem_en = 1'b1; mem_lat = 1;
        repeat (3) next_cycle();
        bus.redirect = 1'b1; bus.redirect_pc = 5'h08; bus.ir_ready = 1'b1;
        push_exp(5'h08); push_exp(5'h09);
        @(negedge clk);
        n_tests++; if (bus.ir_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rc_pre: got ir_valid=%b req=%b expected 1 0", bus.ir_valid, bus.imem_req); end
        next_cycle();
        bus.redirect = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rc_empty: got %b expected 0", bus.ir_valid); end
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 5'h08) begin n_fail++; $display("FAIL rc_next_req: got req=%b addr=%h expected 1 08", bus.imem_req, bus.imem_addr); end
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL rc_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit to;
        int na = 0;
        logic [PC_W-1:0] a0 = '0, a1 = '0;
        do_reset();
        mem_en = 1'b1; mem_lat = 1; bus.ir_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_pc = 5'h1F;
        push_exp(5'h1F); push_exp(5'h00); push_exp(5'h01);
        @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL wrap_cancel_issue: got %b expected 0", bus.imem_req); end
        next_cycle();
        bus.redirect = 1'b0;
        for (int i = 0; i < 20 && na < 2; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                if (na == 0) a0 = bus.imem_addr; else a1 = bus.imem_addr;
                na++;
            end
        end
        n_tests++; if (na != 2 || a0 !== 5'h1F || a1 !== 5'h00) begin n_fail++; $display("FAIL wrap_addrs: got n=%0d %h %h expected 2 1f 00", na, a0, a1); end
        drain(to);
        n_tests++; if (to) begin n_fail++; $display("FAIL wrap_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        next_cycle();
        bus.imem_valid = 1'b1; bus.imem_rdata = instr_of(5'd0);
        next_cycle();
        bus.imem_valid = 1'b0;
        next_cycle();
        #1;
        n_tests++; if (bus.ir_valid !== 1'b1 || bus.pc !== 5'd2) begin n_fail++; $display("FAIL rmw_pre: got ir_valid=%b pc=%h expected 1 02", bus.ir_valid, bus.pc); end
        rst = 1'b1;
        #1;
        n_tests++; if (bus.pc !== 5'd0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rmw_async_pc: got pc=%h req=%b expected 00 0", bus.pc, bus.imem_req); end
        n_tests++; if (bus.ir_valid !== 1'b0 || bus.ir !== '0 || bus.ir_pc !== '0) begin n_fail++; $display("FAIL rmw_async_q: got v=%b ir=%h pc=%h expected 0 0 0", bus.ir_valid, bus.ir, bus.ir_pc); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.imem_valid = 1'b1; bus.imem_rdata = 13'h1ABC;
        next_cycle();
        bus.imem_valid = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_late_valid: got %b expected 0", bus.ir_valid); end
        @(negedge clk);
        n_tests++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_late_valid2: got %b expected 0", bus.ir_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_coincident();
        test_wrap();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
